// File: rtl/tpu_instr_pkg.sv
// Shared definitions for the 88-bit TPU instruction word: field positions,
// the command entry type, the issuer FSM states and the packing helper.
package tpu_instr_pkg;

  localparam int INSTR_W = 88;

  // Field positions, shared with the instruction decoder.
  localparam int PULSE_LSB     = 0;   // {wr_valid_2, wr_valid_1, rd_transpose, rd_start, sys_switch}
  localparam int PULSE_MSB     = 4;
  localparam int COL_SIZE_LSB  = 5;
  localparam int COL_SIZE_MSB  = 6;
  localparam int ROW_SIZE_LSB  = 7;
  localparam int ROW_SIZE_MSB  = 14;
  localparam int RD_ADDR_LSB   = 15;
  localparam int RD_ADDR_MSB   = 16;
  localparam int PTR_SEL_LSB   = 17;
  localparam int PTR_SEL_MSB   = 19;
  localparam int DATA_1_LSB    = 20;
  localparam int DATA_1_MSB    = 35;
  localparam int DATA_2_LSB    = 36;
  localparam int DATA_2_MSB    = 51;
  localparam int PATHWAY_LSB   = 52;
  localparam int PATHWAY_MSB   = 55;
  localparam int INV_BATCH_LSB = 56;
  localparam int INV_BATCH_MSB = 71;
  localparam int LEAK_LSB      = 72;
  localparam int LEAK_MSB      = 87;

  // One queued command, without its idle-gap field (the gap width is a
  // per-instance parameter and travels next to this entry in the FIFO).
  typedef struct packed {
    logic [15:0] leak;
    logic [15:0] inv_batch;
    logic [3:0]  pathway;
    logic [15:0] data_2;
    logic [15:0] data_1;
    logic [2:0]  ptr_sel;
    logic [1:0]  rd_addr;
    logic [7:0]  row_size;
    logic [1:0]  col_size;
    logic [4:0]  pulse;
  } cmd_t;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } issue_state_t;

  // Places every command field at its slot in the instruction word.
  function automatic logic [INSTR_W-1:0] pack_instr(input cmd_t c);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[PULSE_MSB:PULSE_LSB]         = c.pulse;
    w[COL_SIZE_MSB:COL_SIZE_LSB]   = c.col_size;
    w[ROW_SIZE_MSB:ROW_SIZE_LSB]   = c.row_size;
    w[RD_ADDR_MSB:RD_ADDR_LSB]     = c.rd_addr;
    w[PTR_SEL_MSB:PTR_SEL_LSB]     = c.ptr_sel;
    w[DATA_1_MSB:DATA_1_LSB]       = c.data_1;
    w[DATA_2_MSB:DATA_2_LSB]       = c.data_2;
    w[PATHWAY_MSB:PATHWAY_LSB]     = c.pathway;
    w[INV_BATCH_MSB:INV_BATCH_LSB] = c.inv_batch;
    w[LEAK_MSB:LEAK_LSB]           = c.leak;
    return w;
  endfunction

  // Bits that are only meaningful in the issue cycle (pulses and data lanes).
  function automatic logic [INSTR_W-1:0] volatile_mask();
    logic [INSTR_W-1:0] m;
    m = '0;
    m[PULSE_MSB:PULSE_LSB]   = '1;
    m[DATA_2_MSB:DATA_1_LSB] = '1;
    return m;
  endfunction

  localparam logic [INSTR_W-1:0] VOLATILE_MASK = volatile_mask();

endpackage

// File: rtl/instr_issuer_if.sv
// Command channel from the host/sequencer into the instruction issuer.
interface instr_issuer_if #(
  parameter int GAP_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [4:0]       cmd_pulse;
  logic [1:0]       cmd_col_size;
  logic [7:0]       cmd_row_size;
  logic [1:0]       cmd_rd_addr;
  logic [2:0]       cmd_ptr_sel;
  logic [15:0]      cmd_data_1;
  logic [15:0]      cmd_data_2;
  logic [3:0]       cmd_pathway;
  logic [15:0]      cmd_inv_batch;
  logic [15:0]      cmd_leak;
  logic [GAP_W-1:0] cmd_gap;

  modport master (
    output cmd_valid, cmd_pulse, cmd_col_size, cmd_row_size, cmd_rd_addr,
           cmd_ptr_sel, cmd_data_1, cmd_data_2, cmd_pathway, cmd_inv_batch,
           cmd_leak, cmd_gap,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_pulse, cmd_col_size, cmd_row_size, cmd_rd_addr,
           cmd_ptr_sel, cmd_data_1, cmd_data_2, cmd_pathway, cmd_inv_batch,
           cmd_leak, cmd_gap,
    output cmd_ready
  );
endinterface

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO with flush; head entry is visible on dout when not empty.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush empties the queue and wins over push and pop.
  // NOTE: clocked state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Entry storage write.
  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: queues host commands, packs each into the 88-bit
// instruction word for one issue cycle and spaces issues by a per-command gap.
module instr_issuer
  import tpu_instr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_W      = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  instr_issuer_if.slave      cmd,
  input  logic               flush,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_issue,
  output logic               busy,
  output logic [CNT_W-1:0]   issued_count
);
  localparam int ENTRY_W = $bits(cmd_t) + GAP_W;

  cmd_t               in_cmd;
  cmd_t               head_cmd;
  logic [GAP_W-1:0]   head_gap;
  logic [ENTRY_W-1:0] head_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  issue_state_t       state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  assign in_cmd = '{
    leak:      cmd.cmd_leak,
    inv_batch: cmd.cmd_inv_batch,
    pathway:   cmd.cmd_pathway,
    data_2:    cmd.cmd_data_2,
    data_1:    cmd.cmd_data_1,
    ptr_sel:   cmd.cmd_ptr_sel,
    rd_addr:   cmd.cmd_rd_addr,
    row_size:  cmd.cmd_row_size,
    col_size:  cmd.cmd_col_size,
    pulse:     cmd.cmd_pulse
  };

  assign {head_gap, head_cmd} = head_entry;
  assign cmd.cmd_ready        = !fifo_full;
  assign busy                 = !fifo_empty || (state_q == GAP);

  cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd.cmd_valid),
    .pop   (pop),
    .flush (flush),
    .din   ({cmd.cmd_gap, in_cmd}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (head_entry)
  );

  // FSM and gap counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Next state: pop in IDLE, count the idle gap down in GAP, flush aborts.
  // NOTE: defaults come first so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = IDLE;
      gap_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop = 1'b1;
            if (head_gap != '0) begin
              state_d = GAP;
              gap_d   = head_gap;
            end
          end
        end
        GAP: begin
          if (gap_q == GAP_W'(1)) begin
            state_d = IDLE;
            gap_d   = '0;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          gap_d   = '0;
        end
      endcase
    end
  end

  // Output word: load the popped command, otherwise clear pulse/data and keep config.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction  <= '0;
      instr_issue  <= 1'b0;
      issued_count <= '0;
    end else if (pop) begin
      instruction  <= pack_instr(head_cmd);
      instr_issue  <= 1'b1;
      issued_count <= issued_count + CNT_W'(1);
    end else begin
      instruction  <= instruction & ~VOLATILE_MASK;
      instr_issue  <= 1'b0;
    end
  end

endmodule

// File: doc/instr_issuer.md
Name: instr_issuer

Overview:
- Transmit side of the 88-bit TPU instruction word: it produces the word that the instruction decoder consumes.
- Accepts field-level commands from the host/sequencer over a valid/ready handshake and buffers them in a small FIFO.
- Packs each command into the fixed instruction layout and drives it for exactly one issue cycle.
- Inserts a programmable number of idle cycles between issues so multi-cycle TPU operations can drain.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- GAP_W, 4, width of the per-command idle-gap field
- CNT_W, 16, width of the issued-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_pulse  in  5  {wr_valid_2, wr_valid_1, rd_transpose, rd_start, sys_switch}
- cmd_col_size  in  2  UB read column size
- cmd_row_size  in  8  UB read row size
- cmd_rd_addr  in  2  UB read address
- cmd_ptr_sel  in  3  UB pointer select
- cmd_data_1  in  16  host write data lane 1
- cmd_data_2  in  16  host write data lane 2
- cmd_pathway  in  4  VPU data pathway
- cmd_inv_batch  in  16  inverse batch size ×2 (fixed point)
- cmd_leak  in  16  VPU leak factor
- cmd_gap  in  GAP_W  idle cycles to insert after this command issues
- flush  in  1  synchronous: discard queued commands, abort gap
- instruction  out  88  packed instruction word
- instr_issue  out  1  high in the cycle a new command is on instruction
- busy  out  1  FIFO non-empty or state GAP
- issued_count  out  CNT_W  commands issued, wraps modulo 2^CNT_W

Behaviour:
- Layout (fixed):
  - [0] sys_switch; [1] rd_start; [2] rd_transpose; [3] wr_valid_1; [4] wr_valid_2
  - [6:5] col_size; [14:7] row_size; [16:15] rd_addr; [19:17] ptr_sel
  - [35:20] data_1; [51:36] data_2; [55:52] pathway; [71:56] inv_batch; [87:72] leak
- Field classes:
  - Pulse fields [4:0] and data fields [51:20] are non-zero only when instr_issue=1; zero in every other cycle.
  - Config fields ([19:5], [87:52]) are sticky: they hold the last issued values until the next issue.
- Reset: FIFO emptied, state IDLE, gap counter 0, instruction=88'h0, instr_issue=0, issued_count=0. cmd_ready=1 after reset.
- Push: when cmd_valid && cmd_ready at a clock edge. cmd_ready is !full only; there is no pass-through when full, even if a pop happens in the same cycle.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head. Next cycle: instruction=packed head, instr_issue=1, issued_count+1. Go to GAP with counter=cmd_gap if cmd_gap≠0; otherwise stay IDLE, so back-to-back issue is possible.
  - GAP: no pop, instr_issue=0, counter decrements each cycle. When counter reaches 1, go to IDLE. IDLE may pop in the same cycle it is entered from GAP.
- Spacing with gap=N: consecutive issues are exactly N+1 cycles apart. With gap=0: one issue per cycle while the FIFO stays non-empty.
- Latency: command accepted at edge t into an empty FIFO with FSM in IDLE → instr_issue high during cycle t+2 (after edges t+1 and t+2).
- Simultaneous push and pop (FIFO not full): both occur, occupancy unchanged.
- flush:
  - FIFO emptied, state IDLE, pulse and data fields zeroed next cycle; sticky config retained.
  - A push in the same cycle as flush is dropped.
  - flush has priority over pop.
- Reset mid-gap or mid-issue: immediate return to reset values (asynchronous).
- issued_count wraps from 2^CNT_W−1 to 0.

Decomposition:
- Package tpu_instr_pkg holds:
  - INSTR_W=88
  - LSB/MSB localparams for every field (shared with the decoder)
  - Packed struct type for the command entry
  - FSM state enum {IDLE, GAP}
- Sub-module cmd_fifo:
  - Synchronous FIFO with parameters WIDTH and DEPTH, plus flush
  - Ports: push, pop, full, empty, dout (head visible when not empty)

Test Plan:
- Single command (pulse=5'b00010, row_size=8'd2, col_size=2'd2, data_1=16'h1234, gap=0) accepted at t → cycle t+2: instruction[1]=1, [14:7]=2, [6:5]=2, [35:20]=16'h1234, instr_issue=1. Cycle t+3: [4:0]=0, [35:20]=0, [14:7] still 2, issued_count=1.
- Two commands, first with gap=3 → instr_issue high in cycles t+2 and t+6 only; busy low from t+7.
- Five back-to-back commands, gap=15 each → first issues at t+2; after 4 more pushes cmd_ready=0; fifth command held by its source until the FIFO has space; all five issue in order, 16 cycles apart.
- rst asserted during GAP with 2 entries queued → same cycle: instruction=0, instr_issue=0, busy=0, issued_count=0, cmd_ready=1. Subsequent new command issues with the normal 2-cycle latency.
- flush with 3 queued, config leak=16'h0100 issued earlier → busy=0 next cycle, no further issues, instruction[87:72] stays 16'h0100.
- Preload issued_count to 16'hFFFF via 65535 gap=0 issues, then one more → issued_count=0.
